// File: rtl/poly_tone_synth.sv
// Polyphonic square-wave synth: 12 keys, VOICES sticky voices with release envelopes, amplitude mix and PWM.
// Latency: key -> keys_q 1 clk, voice busy +1, tone after one half-period, mix/pwm +1 each; no backpressure.
module poly_tone_synth #(
    parameter int VOICES       = 4,
    parameter int CNT_W        = 16,
    parameter int OCT_W        = 3,
    parameter int RELEASE_STEP = 1024,
    localparam int MIX_W       = 4 + $clog2(VOICES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [11:0]       keys,
    input  logic [OCT_W-1:0]  octave,
    output logic [VOICES-1:0] voice_tone,
    output logic [VOICES-1:0] voice_busy,
    output logic [MIX_W-1:0]  mix,
    output logic              pwm_out
);

    localparam int VW    = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int PRE_W = (RELEASE_STEP > 1) ? $clog2(RELEASE_STEP) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_REL    = 2'd2;

    function automatic logic [15:0] note_div(input logic [3:0] k);
        case (k)
            4'd1:    note_div = 16'd18039;
            4'd2:    note_div = 16'd17026;
            4'd3:    note_div = 16'd16071;
            4'd4:    note_div = 16'd15169;
            4'd5:    note_div = 16'd14317;
            4'd6:    note_div = 16'd13514;
            4'd7:    note_div = 16'd12755;
            4'd8:    note_div = 16'd12039;
            4'd9:    note_div = 16'd11364;
            4'd10:   note_div = 16'd10726;
            4'd11:   note_div = 16'd10124;
            default: note_div = 16'd19111;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] half_period(input logic [3:0] k, input logic [OCT_W-1:0] o);
        logic [15:0] s;
        s = note_div(k) >> o;
        half_period = (s == 16'd0) ? CNT_W'(1) : CNT_W'(s);
    endfunction

    logic [11:0]       keys_q;
    logic [OCT_W-1:0]  octave_q;
    logic [1:0]        st_q   [VOICES];
    logic [1:0]        st_d   [VOICES];
    logic [3:0]        key_q  [VOICES];
    logic [3:0]        key_d  [VOICES];
    logic [3:0]        amp_q  [VOICES];
    logic [3:0]        amp_d  [VOICES];
    logic [CNT_W-1:0]  cnt_q  [VOICES];
    logic [CNT_W-1:0]  cnt_d  [VOICES];
    logic [PRE_W-1:0]  pre_q  [VOICES];
    logic [PRE_W-1:0]  pre_d  [VOICES];
    logic [CNT_W-1:0]  hp     [VOICES];
    logic [VOICES-1:0] tone_q, tone_d;
    logic [MIX_W-1:0]  mix_q, mix_d;
    logic [MIX_W-1:0]  pwm_cnt_q;
    logic              pwm_q;

    logic [11:0]       owned;
    logic              cand_vld, idle_vld, rel_vld, tgt_vld;
    logic [3:0]        cand;
    logic [VW-1:0]     idle_idx, rel_idx, tgt_idx;

    // Allocation: lowest free key onto lowest IDLE voice, else steal lowest RELEASE voice.
    always_comb begin
        owned    = '0;
        cand_vld = 1'b0;
        cand     = '0;
        idle_vld = 1'b0;
        idle_idx = '0;
        rel_vld  = 1'b0;
        rel_idx  = '0;
        for (int v = 0; v < VOICES; v++)
            if (st_q[v] != ST_IDLE) owned[key_q[v]] = 1'b1;
        for (int k = 11; k >= 0; k--)
            if (keys_q[k] && !owned[k]) begin
                cand_vld = 1'b1;
                cand     = 4'(k);
            end
        for (int v = VOICES - 1; v >= 0; v--) begin
            if (st_q[v] == ST_IDLE) begin
                idle_vld = 1'b1;
                idle_idx = VW'(v);
            end
            if (st_q[v] == ST_REL) begin
                rel_vld = 1'b1;
                rel_idx = VW'(v);
            end
        end
        tgt_vld = cand_vld && (idle_vld || rel_vld);
        tgt_idx = idle_vld ? idle_idx : rel_idx;
    end

    always_comb begin
        tone_d = tone_q;
        for (int v = 0; v < VOICES; v++) begin
            hp[v]    = half_period(key_q[v], octave_q);
            st_d[v]  = st_q[v];
            key_d[v] = key_q[v];
            amp_d[v] = amp_q[v];
            cnt_d[v] = cnt_q[v];
            pre_d[v] = pre_q[v];
            // >= rather than == so a shorter period after an octave change wraps at once.
            if (st_q[v] != ST_IDLE) begin
                if (cnt_q[v] >= hp[v] - CNT_W'(1)) begin
                    cnt_d[v]  = '0;
                    tone_d[v] = ~tone_q[v];
                end else begin
                    cnt_d[v] = cnt_q[v] + CNT_W'(1);
                end
            end
            case (st_q[v])
                ST_ACTIVE: begin
                    if (!keys_q[key_q[v]]) begin
                        st_d[v]  = ST_REL;
                        pre_d[v] = '0;
                    end
                end
                ST_REL: begin
                    if (keys_q[key_q[v]]) begin
                        st_d[v]  = ST_ACTIVE;
                        amp_d[v] = 4'd15;
                    end else if (pre_q[v] == PRE_W'(RELEASE_STEP - 1)) begin
                        pre_d[v] = '0;
                        if (amp_q[v] <= 4'd1) begin
                            st_d[v]   = ST_IDLE;
                            amp_d[v]  = '0;
                            cnt_d[v]  = '0;
                            tone_d[v] = 1'b0;
                        end else begin
                            amp_d[v] = amp_q[v] - 4'd1;
                        end
                    end else begin
                        pre_d[v] = pre_q[v] + PRE_W'(1);
                    end
                end
                default: ;
            endcase
            if (tgt_vld && tgt_idx == VW'(v)) begin
                st_d[v]   = ST_ACTIVE;
                key_d[v]  = cand;
                amp_d[v]  = 4'd15;
                cnt_d[v]  = '0;
                pre_d[v]  = '0;
                tone_d[v] = 1'b0;
            end
        end
    end

    always_comb begin
        mix_d = '0;
        for (int v = 0; v < VOICES; v++)
            if (tone_q[v]) mix_d = mix_d + MIX_W'(amp_q[v]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            keys_q    <= '0;
            octave_q  <= '0;
            tone_q    <= '0;
            mix_q     <= '0;
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
            for (int v = 0; v < VOICES; v++) begin
                st_q[v]  <= ST_IDLE;
                key_q[v] <= '0;
                amp_q[v] <= '0;
                cnt_q[v] <= '0;
                pre_q[v] <= '0;
            end
        end else begin
            keys_q    <= keys;
            octave_q  <= octave;
            tone_q    <= tone_d;
            mix_q     <= mix_d;
            pwm_cnt_q <= pwm_cnt_q + MIX_W'(1);
            pwm_q     <= (pwm_cnt_q < mix_q);
            for (int v = 0; v < VOICES; v++) begin
                st_q[v]  <= st_d[v];
                key_q[v] <= key_d[v];
                amp_q[v] <= amp_d[v];
                cnt_q[v] <= cnt_d[v];
                pre_q[v] <= pre_d[v];
            end
        end
    end

    always_comb begin
        for (int v = 0; v < VOICES; v++)
            voice_busy[v] = (st_q[v] != ST_IDLE);
    end

    assign voice_tone = ena ? (tone_q & voice_busy) : '0;
    assign mix        = ena ? mix_q : '0;
    assign pwm_out    = ena & pwm_q;

endmodule

// File: tb/tb_poly_tone_synth.sv
// Directed bench for poly_tone_synth: vector table for allocation/steal plus hand sequences for timing corners.
module tb_poly_tone_synth;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [11:0] keys;
    logic [2:0] octave;
    logic [3:0] voice_tone;
    logic [3:0] voice_busy;
    logic [5:0] mix;
    logic       pwm_out;

    poly_tone_synth #(
        .VOICES(4), .CNT_W(16), .OCT_W(3), .RELEASE_STEP(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .keys(keys), .octave(octave),
        .voice_tone(voice_tone), .voice_busy(voice_busy), .mix(mix), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          rst;
        logic [11:0] keys;
        logic [2:0]  oct;
        bit          ena;
        int          n;
        logic [3:0]  busy;
        logic [3:0]  tone;
        logic [5:0]  mix;
    } row_t;

    row_t tbl [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_row(input int i);
        rst_n  = !tbl[i].rst;
        keys   = tbl[i].keys;
        octave = tbl[i].oct;
        ena    = tbl[i].ena;
        step(tbl[i].n);
        chk($sformatf("row%0d busy", i), 32'(voice_busy), 32'(tbl[i].busy));
        chk($sformatf("row%0d tone", i), 32'(voice_tone), 32'(tbl[i].tone));
        chk($sformatf("row%0d mix", i),  32'(mix),        32'(tbl[i].mix));
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        keys   = '0;
        octave = '0;
        ena    = 1'b1;
        step(1);
        rst_n  = 1'b1;
    endtask

    // Expected square wave of a voice allocated at edge a with half-period hp.
    function automatic logic sq(input int e, input int a, input int hp);
        return (((e - a) / hp) % 2) == 1;
    endfunction

    initial begin
        int mt, mb, hi, zt;
        logic [3:0] exp_t, exp_b;

        //               rst   keys     oct   ena  n    busy  tone  mix
        tbl[0]  = '{1'b1, 12'h000, 3'd0, 1'b1, 1,   4'h0, 4'h0, 6'd0};
        tbl[1]  = '{1'b0, 12'h001, 3'd7, 1'b1, 1,   4'h0, 4'h0, 6'd0};
        tbl[2]  = '{1'b0, 12'h009, 3'd7, 1'b1, 1,   4'h1, 4'h0, 6'd0};
        tbl[3]  = '{1'b0, 12'h00D, 3'd7, 1'b1, 1,   4'h3, 4'h0, 6'd0};
        tbl[4]  = '{1'b0, 12'h00D, 3'd7, 1'b1, 1,   4'h7, 4'h0, 6'd0};
        tbl[5]  = '{1'b0, 12'h00C, 3'd7, 1'b1, 1,   4'h7, 4'h0, 6'd0};
        tbl[6]  = '{1'b0, 12'h00C, 3'd7, 1'b1, 1,   4'h7, 4'h0, 6'd0};
        tbl[7]  = '{1'b1, 12'h000, 3'd7, 1'b1, 1,   4'h0, 4'h0, 6'd0};
        tbl[8]  = '{1'b0, 12'h01F, 3'd7, 1'b1, 1,   4'h0, 4'h0, 6'd0};
        tbl[9]  = '{1'b0, 12'h01F, 3'd7, 1'b1, 1,   4'h1, 4'h0, 6'd0};
        tbl[10] = '{1'b0, 12'h01F, 3'd7, 1'b1, 1,   4'h3, 4'h0, 6'd0};
        tbl[11] = '{1'b0, 12'h01F, 3'd7, 1'b1, 1,   4'h7, 4'h0, 6'd0};
        tbl[12] = '{1'b0, 12'h01F, 3'd7, 1'b1, 1,   4'hF, 4'h0, 6'd0};
        tbl[13] = '{1'b0, 12'h01F, 3'd7, 1'b1, 140, 4'hF, 4'hE, 6'd45};
        tbl[14] = '{1'b0, 12'h01D, 3'd7, 1'b1, 1,   4'hF, 4'hE, 6'd45};
        tbl[15] = '{1'b0, 12'h01D, 3'd7, 1'b1, 1,   4'hF, 4'hE, 6'd45};
        tbl[16] = '{1'b0, 12'h01D, 3'd7, 1'b1, 1,   4'hF, 4'hC, 6'd45};
        tbl[17] = '{1'b0, 12'h01D, 3'd7, 1'b1, 1,   4'hF, 4'hC, 6'd30};

        rst_n = 1'b0; keys = '0; octave = '0; ena = 1'b1;

        // Polyphony: C->v0, D#->v1, D->v2, then C released.
        for (int i = 0; i <= 6; i++) run_row(i);

        // v1 (D#, hp 125, edge 3) and v2 (D, hp 133, edge 4) keep phase; v0 idles 60 edges after release.
        mt = 0; mb = 0;
        for (int e = 7; e <= 400; e++) begin
            step(1);
            exp_t = {1'b0, sq(e, 4, 133), sq(e, 3, 125), 1'b0};
            exp_b = (e < 66) ? 4'b0111 : 4'b0110;
            if (voice_tone !== exp_t) mt++;
            if (voice_busy !== exp_b) mb++;
        end
        chk("sticky tone phase errors", mt, 0);
        chk("release busy errors", mb, 0);

        // Mid-note reset then overflow/steal.
        for (int i = 7; i <= 17; i++) run_row(i);

        // Single key, octave 7: half-period 149, pwm duty.
        do_reset();
        keys = 12'h001; octave = 3'd7;
        step(1); chk("single busy N", 32'(voice_busy), 0);
        step(1); chk("single busy N+1", 32'(voice_busy), 1);
        step(148); chk("single tone before rise", 32'(voice_tone), 0);
        step(1); chk("single tone rise", 32'(voice_tone), 1);
        chk("single mix lag", 32'(mix), 0);
        step(1); chk("single mix high", 32'(mix), 15);
        hi = 0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            if (pwm_out) hi++;
        end
        chk("pwm duty mix15", hi, 15);
        step(83); chk("single tone end high", 32'(voice_tone), 1);
        step(1); chk("single tone fall", 32'(voice_tone), 0);
        step(1); chk("single mix fall", 32'(mix), 0);

        // Release envelope, RELEASE_STEP=4, released while tone high.
        do_reset();
        keys = 12'h001; octave = 3'd7;
        step(2);
        step(148);
        keys = 12'h000;
        step(2); chk("rel entry busy", 32'(voice_busy), 1);
        step(1); chk("rel mix k0", 32'(mix), 15);
        for (int k = 1; k <= 14; k++) begin
            step(4);
            chk($sformatf("rel mix k%0d", k), 32'(mix), 32'(15 - k));
        end
        step(2); chk("rel busy E+59", 32'(voice_busy), 1);
        step(1); chk("rel busy E+60", 32'(voice_busy), 0);
        chk("rel tone idle", 32'(voice_tone), 0);
        step(1); chk("rel mix idle", 32'(mix), 0);

        // Octave change mid-note, both directions.
        do_reset();
        keys = 12'h001; octave = 3'd7;
        step(2);
        step(139); octave = 3'd6;
        step(158); chk("oct7to6 before wrap", 32'(voice_tone), 0);
        step(1); chk("oct7to6 wrap at 298", 32'(voice_tone), 1);
        step(199); octave = 3'd7;
        step(1); chk("oct6to7 cnt200 hold", 32'(voice_tone), 1);
        step(1); chk("oct6to7 immediate wrap", 32'(voice_tone), 0);
        step(148); chk("oct7 next before", 32'(voice_tone), 0);
        step(1); chk("oct7 next wrap", 32'(voice_tone), 1);

        // ena low: audible outputs muted, state keeps running.
        ena = 1'b0;
        step(1);
        chk("ena0 tone", 32'(voice_tone), 0);
        chk("ena0 mix", 32'(mix), 0);
        chk("ena0 busy", 32'(voice_busy), 1);
        hi = 0; zt = 0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            if (pwm_out) hi++;
            if (mix != 0 || voice_tone != 0) zt++;
        end
        chk("ena0 pwm high count", hi, 0);
        chk("ena0 audible count", zt, 0);
        ena = 1'b1;
        step(1);
        chk("ena1 tone resumes", 32'(voice_tone), 1);
        chk("ena1 mix resumes", 32'(mix), 15);

        // One-cycle reset mid-note.
        rst_n = 1'b0;
        step(1);
        chk("midrst busy", 32'(voice_busy), 0);
        chk("midrst tone", 32'(voice_tone), 0);
        chk("midrst mix", 32'(mix), 0);
        chk("midrst pwm", 32'(pwm_out), 0);
        rst_n = 1'b1;
        step(2);
        chk("post rst realloc busy", 32'(voice_busy), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
